fpu_unit: RTL and testbench
===========================

Name: fpu_unit

Overview:
- IEEE-754 single-precision floating-point add/subtract unit with one registered result stage.
- Selects add or subtract from an opcode and computes the result combinationally from the current operands.
- Registers the result on the clock.
- Sits as the arithmetic leaf of the FPU datapath; the issuing logic holds the operands and reads the result one cycle later.

Parameters:
- NUM_OP, 1, width of the opcode bus i_fpu_op. Only bit 0 is decoded; upper bits are reserved and ignored.

Ports:
- i_clk  input  1  single clock, rising-edge active.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_fpu_op  input  NUM_OP  operation select: bit0 = 0 is add (a + b), bit0 = 1 is subtract (a - b).
- i_floating_a  input  32  operand A, IEEE-754 binary32 {sign, exp[7:0], frac[22:0]}.
- i_floating_b  input  32  operand B, IEEE-754 binary32.
- o_floating_result  output  32  registered result, IEEE-754 binary32.

Behaviour:
- Reset:
  - i_rst_n low asynchronously clears o_floating_result to 32'h00000000.
  - The output holds that value until the first rising edge after reset release.
  - Reset asserted mid-operation discards the pending result.
- Latency and handshake:
  - The result of the inputs present at a rising edge appears on o_floating_result after that edge (1-cycle latency).
  - Throughput is one operation per cycle.
  - There is no handshake; the output updates every cycle.
- Subtract is implemented as add with the sign of B inverted.
- Datapath:
  - Unpack each operand. Exponent 0 means the operand is zero (denormals flushed to zero, sign kept). Otherwise the significand is {1, frac}.
  - Swap so the operand with the larger magnitude is first.
  - Right-shift the smaller significand by the exponent difference, keeping guard, round and sticky bits.
  - A shift of 27 or more leaves only sticky.
  - Same effective sign: add. On carry-out, shift right 1 and increment the exponent.
  - Different effective sign: subtract the smaller from the larger. Normalise with a leading-zero count and left shift, decrementing the exponent.
  - Round to nearest, ties to even. A rounding carry renormalises and increments the exponent.
  - Result sign is the sign of the larger-magnitude operand.
- Special cases, applied in priority order:
  1. Any NaN input gives 32'h7FC00000.
  2. +Inf + -Inf (after the effective sign is applied) gives 32'h7FC00000.
  3. Inf with a finite operand gives that Inf (with its effective sign); Inf + Inf of the same sign gives that Inf.
  4. Both operands zero: the result sign is the AND of the effective signs.
  5. An exact-zero result from cancellation gives +0 (32'h00000000).
  6. Exponent overflow (final exponent 255 or more) gives signed Inf (sign, 8'hFF, 0).
  7. Exponent underflow (final exponent 0 or less) is flushed to signed zero.
- No exception flags are produced.

Test Plan:
- Reset: hold i_rst_n = 0 with arbitrary inputs -> o_floating_result = 32'h00000000. Release reset, op = 0, a = 32'h40B00000 (5.5), b = 32'h4019999A (2.4) -> after the next rising edge the output is 32'h40FCCCCD (7.9).
- Subtract: op = 1, a = 32'h41200000 (10.0), b = 32'h40600000 (3.5) -> 32'h40D00000 (6.5), one cycle later.
- Mixed signs: op = 0, a = 32'hC0900000 (-4.5), b = 32'h40100000 (2.25) -> 32'hC0100000 (-2.25).
- Small operands and back-to-back ops:
  - op = 1, a = 32'h3E000000 (0.125), b = 32'h3D800000 (0.0625) -> 32'h3D800000 (0.0625).
  - Changing operands every cycle yields each result exactly one cycle after its inputs.
- Rounding:
  - 32'h3F800000 + 32'h33800000 (tie) -> 32'h3F800000.
  - 32'h3F800000 + 32'h33800001 -> 32'h3F800001.
  - 32'h3F800001 + 32'h33800000 -> 32'h3F800002.
- Specials:
  - a - a with a = 32'h40490FDB -> 32'h00000000.
  - 32'h7F800000 - 32'h7F800000 -> 32'h7FC00000.
  - 32'h7F7FFFFF + 32'h7F7FFFFF -> 32'h7F800000.
  - Any operand 32'h7FC00001 -> 32'h7FC00000.
  - Asserting i_rst_n low mid-stream clears the output immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fpu_unit.sv
// IEEE-754 binary32 add/subtract with one registered result stage.
// Denormals are flushed to zero; rounding is nearest-even; no exception flags.
module fpu_unit #(
    parameter int NUM_OP = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_OP-1:0] i_fpu_op,
    input  logic [31:0]       i_floating_a,
    input  logic [31:0]       i_floating_b,
    output logic [31:0]       o_floating_result
);

    localparam logic [31:0] QNAN = 32'h7FC00000;

    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    logic              sa, sb;
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [23:0]       ma, mb;
    logic              a_ge_b;
    logic              sl, ss, eff_sub;
    logic [7:0]        el, es, ediff;
    logic [23:0]       ml, ms;
    logic [26:0]       small_ext, small_sh, lost_mask;
    logic [27:0]       sum;
    logic [26:0]       dif, norm;
    logic [4:0]        lz;
    logic signed [9:0] exp_pre, exp_fin;
    logic              round_up;
    logic [24:0]       rnd;
    logic [22:0]       frac_fin;
    logic [31:0]       result_d, result_q;

    // Subtraction is addition with B's sign flipped; only op bit 0 is decoded.
    assign sa = i_floating_a[31];
    assign sb = i_floating_b[31] ^ i_fpu_op[0];
    assign ea = i_floating_a[30:23];
    assign eb = i_floating_b[30:23];
    assign fa = i_floating_a[22:0];
    assign fb = i_floating_b[22:0];

    assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign ma     = a_zero ? 24'd0 : {1'b1, fa};
    assign mb     = b_zero ? 24'd0 : {1'b1, fb};
    assign a_ge_b = {ea, ma} >= {eb, mb};

    always_comb begin
        sl        = a_ge_b ? sa : sb;
        ss        = a_ge_b ? sb : sa;
        el        = a_ge_b ? ea : eb;
        es        = a_ge_b ? eb : ea;
        ml        = a_ge_b ? ma : mb;
        ms        = a_ge_b ? mb : ma;
        eff_sub   = sl ^ ss;
        ediff     = el - es;
        small_ext = {ms, 3'b000};
        lost_mask = '0;
        small_sh  = '0;
        norm      = '0;
        lz        = '0;
        exp_pre   = '0;

        // Alignment keeps guard/round bits; everything shifted past them folds into sticky.
        if (ediff >= 8'd27) begin
            small_sh = {26'd0, |ms};
        end else begin
            lost_mask   = (27'd1 << ediff[4:0]) - 27'd1;
            small_sh    = small_ext >> ediff[4:0];
            small_sh[0] = small_sh[0] | (|(small_ext & lost_mask));
        end

        sum = {1'b0, ml, 3'b000} + {1'b0, small_sh};
        dif = {ml, 3'b000} - small_sh;

        if (!eff_sub) begin
            if (sum[27]) begin
                norm    = {sum[27:2], sum[1] | sum[0]};
                exp_pre = $signed({2'b00, el}) + 10'sd1;
            end else begin
                norm    = sum[26:0];
                exp_pre = $signed({2'b00, el});
            end
        end else begin
            lz      = lzc27(dif);
            norm    = dif << lz;
            exp_pre = $signed({2'b00, el}) - $signed({5'd0, lz});
        end

        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        rnd      = {1'b0, norm[26:3]} + {24'd0, round_up};
        if (rnd[24]) begin
            frac_fin = rnd[23:1];
            exp_fin  = exp_pre + 10'sd1;
        end else begin
            frac_fin = rnd[22:0];
            exp_fin  = exp_pre;
        end

        result_d = {sl, exp_fin[7:0], frac_fin};
        if (a_nan || b_nan) begin
            result_d = QNAN;
        end else if (a_inf && b_inf && (sa != sb)) begin
            result_d = QNAN;
        end else if (a_inf) begin
            result_d = {sa, 8'hFF, 23'd0};
        end else if (b_inf) begin
            result_d = {sb, 8'hFF, 23'd0};
        end else if (a_zero && b_zero) begin
            result_d = {sa & sb, 31'd0};
        end else if (eff_sub && (dif == 27'd0)) begin
            result_d = 32'h00000000;
        end else if (exp_fin >= 10'sd255) begin
            result_d = {sl, 8'hFF, 23'd0};
        end else if (exp_fin <= 10'sd0) begin
            result_d = {sl, 31'd0};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            result_q <= 32'h00000000;
        end else begin
            result_q <= result_d;
        end
    end

    assign o_floating_result = result_q;

endmodule

// File: tb/tb_fpu_unit.sv
// Bench for fpu_unit: exact-integer reference model, per-cycle compare, directed vectors.
module tb_fpu_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [0:0]  op = 1'b0;
    logic [31:0] a = 32'h12345678;
    logic [31:0] b = 32'h9ABCDEF0;
    logic [31:0] res;

    int n_tests = 0;
    int n_fail  = 0;
    logic        chk_en = 1'b0;
    logic [31:0] model_q;

    fpu_unit #(.NUM_OP(1)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_fpu_op          (op),
        .i_floating_a      (a),
        .i_floating_b      (b),
        .o_floating_result (res)
    );

    always #5 clk = ~clk;

    // Reference: form the exact signed sum as a wide integer, then round once to nearest-even.
    function automatic logic [31:0] model(input logic [31:0] x, input logic [31:0] y, input logic sub);
        logic sx, sy, shi, slo, sgn;
        logic [7:0] ex, ey, ehi, elo;
        logic [22:0] fx, fy;
        logic [23:0] mhi, mlo;
        int d, e, p, sh;
        logic signed [127:0] vhi, vlo, v;
        logic [127:0] mag, keep, rem, half;
        sx = x[31]; sy = y[31] ^ sub;
        ex = x[30:23]; ey = y[30:23];
        fx = x[22:0];  fy = y[22:0];
        if ((ex == 8'hFF && fx != 0) || (ey == 8'hFF && fy != 0)) return 32'h7FC00000;
        if (ex == 8'hFF && ey == 8'hFF) return (sx == sy) ? {sx, 8'hFF, 23'd0} : 32'h7FC00000;
        if (ex == 8'hFF) return {sx, 8'hFF, 23'd0};
        if (ey == 8'hFF) return {sy, 8'hFF, 23'd0};
        if (ex == 0 && ey == 0) return {sx & sy, 31'd0};
        if (ex == 0) return {sy, y[30:0]};
        if (ey == 0) return {sx, x[30:0]};
        if (ex >= ey) begin
            shi = sx; ehi = ex; mhi = {1'b1, fx}; slo = sy; elo = ey; mlo = {1'b1, fy};
        end else begin
            shi = sy; ehi = ey; mhi = {1'b1, fy}; slo = sx; elo = ex; mlo = {1'b1, fx};
        end
        d = int'(ehi) - int'(elo);
        e = int'(elo);
        if (d > 40) begin
            mlo = 24'd1;
            d = 40;
            e = int'(ehi) - 40;
        end
        vhi = $signed({104'd0, mhi} << d);
        vlo = $signed({104'd0, mlo});
        if (shi) vhi = -vhi;
        if (slo) vlo = -vlo;
        v = vhi + vlo;
        if (v == 0) return 32'h00000000;
        sgn = (v < 0);
        mag = sgn ? 128'(-v) : 128'(v);
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        if (p >= 23) begin
            sh = p - 23;
            keep = mag >> sh;
            if (sh > 0) begin
                rem  = mag & ((128'd1 << sh) - 128'd1);
                half = 128'd1 << (sh - 1);
                if (rem > half || (rem == half && keep[0])) keep = keep + 128'd1;
            end
            if (keep[24]) begin
                keep = keep >> 1;
                sh = sh + 1;
            end
            e = e + sh;
        end else begin
            keep = mag << (23 - p);
            e = e - (23 - p);
        end
        if (e >= 255) return {sgn, 8'hFF, 23'd0};
        if (e <= 0) return {sgn, 31'd0};
        return {sgn, e[7:0], keep[22:0]};
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0] e;
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0:       e = 8'h00;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(1, 3));
            3:       e = 8'($urandom_range(250, 254));
            default: e = 8'(120 + $urandom_range(0, 15));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_q <= 32'h00000000;
        else        model_q <= model(a, b, op[0]);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_tests++;
            if (res !== model_q) begin
                n_fail++;
                $display("FAIL cycle_model t=%0t: got %h expected %h", $time, res, model_q);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic vec(input string name, input logic vop, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] ex);
        @(negedge clk);
        op = vop; a = va; b = vb;
        check({"model_", name}, model(va, vb, vop), ex);
        @(posedge clk);
        #2;
        check(name, res, ex);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #2;
        check("reset", res, 32'h00000000);
        chk_en = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        vec("add_5p5_2p4",   1'b0, 32'h40B00000, 32'h4019999A, 32'h40FCCCCD);
        vec("sub_10_3p5",    1'b1, 32'h41200000, 32'h40600000, 32'h40D00000);
        vec("mixed_sign",    1'b0, 32'hC0900000, 32'h40100000, 32'hC0100000);
        vec("small_sub",     1'b1, 32'h3E000000, 32'h3D800000, 32'h3D800000);
        vec("tie_even",      1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000);
        vec("above_tie",     1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001);
        vec("tie_odd",       1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002);
        vec("cancel_pi",     1'b1, 32'h40490FDB, 32'h40490FDB, 32'h00000000);
        vec("inf_minus_inf", 1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000);
        vec("overflow",      1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000);
        vec("nan_a",         1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000);
        vec("nan_b",         1'b1, 32'h3F800000, 32'h7FC00001, 32'h7FC00000);
        vec("inf_finite",    1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000);
        vec("neg_zeros",     1'b0, 32'h80000000, 32'h80000000, 32'h80000000);
        vec("nzero_sub_pz",  1'b1, 32'h80000000, 32'h00000000, 32'h80000000);
        vec("pzero_add_nz",  1'b0, 32'h00000000, 32'h80000000, 32'h00000000);
        vec("add_again",     1'b0, 32'h40B00000, 32'h4019999A, 32'h40FCCCCD);

        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", res, 32'h00000000);
        @(negedge clk);
        rst_n = 1'b1;
        vec("after_reset",   1'b1, 32'h41200000, 32'h40600000, 32'h40D00000);

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            op = 1'($urandom);
            a  = rand_fp();
            if ($urandom_range(0, 3) == 0) b = {1'($urandom), a[30:0] ^ 31'($urandom_range(0, 255))};
            else                           b = rand_fp();
        end

        @(negedge clk);
        @(posedge clk);
        #2;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
